// File: rtl/load_pkg.sv
// Shared encodings for the scalar load controller: funct3 codes, response causes,
// FSM states and the request legality check.
package load_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] CAUSE_OK       = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   // Illegal funct3 outranks misalignment.
   function automatic logic [1:0] req_check(input logic [2:0] f3, input logic [1:0] off);
      logic [1:0] cause;
      cause = CAUSE_OK;
      case (f3)
         F3_LB, F3_LBU: cause = CAUSE_OK;
         F3_LH, F3_LHU: cause = off[0] ? CAUSE_MISALIGN : CAUSE_OK;
         F3_LW:         cause = (off != 2'b00) ? CAUSE_MISALIGN : CAUSE_OK;
         default:       cause = CAUSE_ILLEGAL;
      endcase
      return cause;
   endfunction

endpackage

// File: rtl/load_align_ext.sv
// Lane select and sign/zero extension of a read word for one load type.
module load_align_ext
   import load_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v   = word_i[{off_i, 3'b000} +: 8];
      half_v   = word_i[{off_i[1], 4'b0000} +: 16];
      result_o = '0;
      case (funct3_i)
         F3_LB:   result_o = {{24{byte_v[7]}}, byte_v};
         F3_LBU:  result_o = {24'h0, byte_v};
         F3_LH:   result_o = {{16{half_v[15]}}, half_v};
         F3_LHU:  result_o = {16'h0, half_v};
         F3_LW:   result_o = word_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/load_unit_ctrl.sv
// One-outstanding scalar load sequencer: accepts a core load, performs a word
// read, and returns the extended result or an error cause.
module load_unit_ctrl
   import load_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int TW          = 16
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic [31:0] ReqAddr,
   input  logic [2:0]  ReqFunct3,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemGnt,
   input  logic        MemRValid,
   input  logic [31:0] MemRData,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [31:0] RspData,
   output logic [1:0]  RspCause
);

   state_t      state_q;
   logic [1:0]  off_q;
   logic [2:0]  funct3_q;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic [31:0] mem_addr_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_data_q;
   logic [1:0]  rsp_cause_q;
   logic [1:0]  req_cause;
   logic [31:0] ext_data;
   logic        timeout_hit;

   load_align_ext u_align (
      .word_i   (MemRData),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .result_o (ext_data)
   );

   // Saturating so a long grant stall cannot wrap past the timeout compare.
   always_comb begin
      timer_d     = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
      req_cause   = req_check(ReqFunct3, ReqAddr[1:0]);
      timeout_hit = (timer_q >= TW'(TIMEOUT_CYC - 1));
   end

   assign ReqReady = (state_q == IDLE);
   assign MemReq   = (state_q == REQ);
   assign MemAddr  = mem_addr_q;
   assign RspValid = rsp_valid_q;
   assign RspData  = rsp_data_q;
   assign RspCause = rsp_cause_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= IDLE;
         off_q       <= '0;
         funct3_q    <= '0;
         timer_q     <= '0;
         mem_addr_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_cause_q <= CAUSE_OK;
      end else begin
         case (state_q)
            IDLE: begin
               if (ReqValid) begin
                  off_q      <= ReqAddr[1:0];
                  funct3_q   <= ReqFunct3;
                  timer_q    <= '0;
                  mem_addr_q <= {ReqAddr[31:2], 2'b00};
                  if (req_cause != CAUSE_OK) begin
                     rsp_valid_q <= 1'b1;
                     rsp_data_q  <= '0;
                     rsp_cause_q <= req_cause;
                     state_q     <= RESP;
                  end else begin
                     state_q <= REQ;
                  end
               end
            end
            REQ: begin
               timer_q <= timer_d;
               if (MemGnt) begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               timer_q <= timer_d;
               if (MemRValid) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= ext_data;
                  rsp_cause_q <= CAUSE_OK;
                  state_q     <= RESP;
               end else if (timeout_hit) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_cause_q <= CAUSE_TIMEOUT;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (RspReady) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Directed plus randomized bench for load_unit_ctrl against a behavioural load model.
module tb_load_unit_ctrl;

   localparam int TO = 8;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        ReqValid;
   logic        ReqReady;
   logic [31:0] ReqAddr;
   logic [2:0]  ReqFunct3;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemGnt;
   logic        MemRValid;
   logic [31:0] MemRData;
   logic        RspValid;
   logic        RspReady;
   logic [31:0] RspData;
   logic [1:0]  RspCause;

   int n_checks = 0;
   int n_err    = 0;

   load_unit_ctrl #(.TIMEOUT_CYC(TO), .TW(16)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .ReqValid  (ReqValid),
      .ReqReady  (ReqReady),
      .ReqAddr   (ReqAddr),
      .ReqFunct3 (ReqFunct3),
      .MemReq    (MemReq),
      .MemAddr   (MemAddr),
      .MemGnt    (MemGnt),
      .MemRValid (MemRValid),
      .MemRData  (MemRData),
      .RspValid  (RspValid),
      .RspReady  (RspReady),
      .RspData   (RspData),
      .RspCause  (RspCause)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [1:0] m_cause(input logic [31:0] a, input logic [2:0] f);
      if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'd3;
      if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) return 2'd1;
      if (f == 3'd2 && (a % 4 != 0)) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [31:0] m_data(input logic [31:0] a, input logic [2:0] f,
                                          input logic [31:0] w);
      logic [31:0]        v;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      v  = w >> ((a % 4) * 8);
      sb = v[7:0];
      sh = v[15:0];
      case (f)
         3'd0:    return 32'(sb);
         3'd1:    return 32'(sh);
         3'd2:    return w;
         3'd4:    return v & 32'h0000_00FF;
         3'd5:    return v & 32'h0000_FFFF;
         default: return 32'h0;
      endcase
   endfunction

   // Entered and left at #1 after a rising edge with the DUT idle.
   task automatic run_load(input string nm, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] word, input int gnt_dly, input int rv_dly,
                           input int rdy_dly);
      logic [1:0]  ecause;
      logic [31:0] edata;
      int          w_to;
      int          w_end;
      ecause = m_cause(addr, f3);
      chk({nm, "_rdy_idle"}, 32'(ReqReady), 32'd1);
      ReqValid  = 1'b1;
      ReqAddr   = addr;
      ReqFunct3 = f3;
      tick();
      ReqValid = 1'b0;
      ReqAddr  = $urandom;
      if (ecause != 2'd0) begin
         edata = 32'h0;
         chk({nm, "_err_memreq"}, 32'(MemReq), 32'd0);
      end else begin
         for (int c = 0; c <= gnt_dly; c++) begin
            chk({nm, "_req_memreq"}, 32'(MemReq), 32'd1);
            chk({nm, "_req_addr"}, MemAddr, addr & 32'hFFFF_FFFC);
            chk({nm, "_req_rdy"}, 32'(ReqReady), 32'd0);
            chk({nm, "_req_rspv"}, 32'(RspValid), 32'd0);
            MemGnt    = (c == gnt_dly);
            ReqValid  = 1'b1;
            ReqAddr   = $urandom;
            MemRValid = 1'($urandom % 2);
            MemRData  = $urandom;
            tick();
         end
         MemGnt   = 1'b0;
         ReqValid = 1'b0;
         w_to  = TO - 2 - gnt_dly;
         if (w_to < 0) w_to = 0;
         w_end = (rv_dly <= w_to) ? rv_dly : w_to;
         edata = (rv_dly <= w_to) ? m_data(addr, f3, word) : 32'h0;
         ecause = (rv_dly <= w_to) ? 2'd0 : 2'd2;
         for (int w = 0; w <= w_end; w++) begin
            chk({nm, "_wait_memreq"}, 32'(MemReq), 32'd0);
            chk({nm, "_wait_rspv"}, 32'(RspValid), 32'd0);
            MemRValid = (w == rv_dly);
            MemRData  = (w == rv_dly) ? word : $urandom;
            tick();
         end
         MemRValid = 1'b0;
      end
      for (int r = 0; r <= rdy_dly; r++) begin
         chk({nm, "_rsp_valid"}, 32'(RspValid), 32'd1);
         chk({nm, "_rsp_data"}, RspData, edata);
         chk({nm, "_rsp_cause"}, 32'(RspCause), 32'(ecause));
         chk({nm, "_rsp_rdy"}, 32'(ReqReady), 32'd0);
         RspReady = (r == rdy_dly);
         ReqValid = 1'b1;
         ReqAddr  = $urandom;
         tick();
      end
      RspReady = 1'b0;
      ReqValid = 1'b0;
      chk({nm, "_done_rspv"}, 32'(RspValid), 32'd0);
      chk({nm, "_done_rdy"}, 32'(ReqReady), 32'd1);
   endtask

   initial begin
      Rst       = 1'b1;
      ReqValid  = 1'b0;
      ReqAddr   = '0;
      ReqFunct3 = '0;
      MemGnt    = 1'b0;
      MemRValid = 1'b0;
      MemRData  = '0;
      RspReady  = 1'b0;
      tick();
      tick();
      chk("rst_memreq", 32'(MemReq), 32'd0);
      chk("rst_memaddr", MemAddr, 32'h0);
      chk("rst_rspv", 32'(RspValid), 32'd0);
      chk("rst_rspdata", RspData, 32'h0);
      chk("rst_cause", 32'(RspCause), 32'd0);
      chk("rst_rdy", 32'(ReqReady), 32'd1);
      Rst = 1'b0;
      tick();

      run_load("lb",      32'h0000_1003, 3'b000, 32'h80FF_1234, 0, 0, 0);
      run_load("lhu",     32'h0000_2002, 3'b101, 32'hBEEF_0001, 0, 0, 0);
      run_load("lh",      32'h0000_2002, 3'b001, 32'hBEEF_0001, 1, 1, 1);
      run_load("lw_mis",  32'h0000_3001, 3'b010, 32'h1234_5678, 0, 0, 0);
      run_load("f3_ill",  32'h0000_3000, 3'b011, 32'h1234_5678, 0, 0, 2);
      run_load("lw_slow", 32'h0000_4000, 3'b010, 32'hCAFE_F00D, 3, 0, 4);
      run_load("tmo",     32'h0000_5000, 3'b010, 32'h1111_2222, 0, 100, 0);
      run_load("tmo_edge",32'h0000_5004, 3'b010, 32'h3333_4444, 0, TO - 2, 0);
      run_load("lbu_hi",  32'h0000_6002, 3'b100, 32'h00A5_0000, 2, 2, 0);

      // Reset while waiting for read data.
      ReqValid  = 1'b1;
      ReqAddr   = 32'h0000_7000;
      ReqFunct3 = 3'b010;
      tick();
      ReqValid = 1'b0;
      MemGnt   = 1'b1;
      tick();
      MemGnt = 1'b0;
      tick();
      Rst = 1'b1;
      #1;
      chk("mid_rst_memreq", 32'(MemReq), 32'd0);
      chk("mid_rst_memaddr", MemAddr, 32'h0);
      chk("mid_rst_rspv", 32'(RspValid), 32'd0);
      chk("mid_rst_rspdata", RspData, 32'h0);
      chk("mid_rst_cause", 32'(RspCause), 32'd0);
      chk("mid_rst_rdy", 32'(ReqReady), 32'd1);
      tick();
      Rst       = 1'b0;
      MemRValid = 1'b1;
      MemRData  = 32'hDEAD_BEEF;
      tick();
      MemRValid = 1'b0;
      chk("stale_rspv", 32'(RspValid), 32'd0);
      chk("stale_memreq", 32'(MemReq), 32'd0);
      run_load("lbu_after", 32'h0000_8001, 3'b100, 32'h0000_9A00, 0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [2:0]  f;
         a = $urandom;
         if ($urandom % 2 == 0) a[1:0] = 2'b00;
         f = 3'($urandom_range(0, 7));
         run_load("rnd", a, f, $urandom, $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/load_unit_ctrl.md
Name: load_unit_ctrl

Overview:
- Sequences one scalar RISC-V load (LB, LH, LW, LBU, LHU) from core request to 32-bit result.
- Issues a word-aligned memory read, waits for the response, selects the addressed byte or halfword, then sign- or zero-extends it to 32 bits.
- Sits between the execute stage and the data-memory port. Exactly one load is outstanding at a time.
- Reports misaligned accesses, illegal funct3 and memory timeout as error responses.

Parameters:
- TIMEOUT_CYC, 255: cycles allowed from entering REQ until MemRValid before the load aborts with a timeout error. Legal range 2..65535.
- TW, 16: width of the timeout counter. Must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- ReqValid  in  1  core presents a load
- ReqReady  out  1  controller can accept a load
- ReqAddr  in  32  byte address
- ReqFunct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- MemReq  out  1  memory read request
- MemAddr  out  32  word-aligned read address
- MemGnt  in  1  memory accepted the request
- MemRValid  in  1  read data valid
- MemRData  in  32  read data word
- RspValid  out  1  result available
- RspReady  in  1  core consumes the result
- RspData  out  32  extended load data; 0 on error
- RspCause  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal funct3

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE.
  - MemReq=0, MemAddr=0, RspValid=0, RspData=0, RspCause=0.
  - ReqReady=1 once in IDLE.
  - Registered addr, funct3 and timer cleared.
  - Rst asserted mid-operation abandons the load. A MemRValid arriving later in IDLE is ignored.
- IDLE:
  - ReqReady=1 (decoded from state; 0 in every other state).
  - On ReqValid&ReqReady, latch ReqAddr and ReqFunct3, then check in this priority:
    - funct3 not in {000,001,010,100,101}: cause 3.
    - LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: cause 1.
  - Error: go to RESP with RspData=0; no memory access is made.
  - Otherwise go to REQ with timer=0.
- REQ:
  - MemReq=1, MemAddr={addr[31:2],2'b00}. Both held stable until MemGnt.
  - On MemGnt, go to WAIT.
  - MemRValid while in REQ, including the MemGnt cycle, is ignored.
  - Timer increments every cycle in REQ and WAIT.
- WAIT:
  - MemReq=0.
  - On MemRValid, RspData=extract(MemRData), RspCause=0, go to RESP.
  - Else if timer==TIMEOUT_CYC-1, RspCause=2, RspData=0, go to RESP.
  - If MemRValid and timeout coincide, the data wins and cause=0.
- RESP:
  - RspValid=1. RspData and RspCause held stable until RspReady.
  - On RspReady, go to IDLE and RspValid drops the next cycle.
  - A new request is accepted no earlier than the cycle after the handshake.
- extract():
  - Byte = MemRData[8*addr[1:0] +: 8].
  - Half = MemRData[16*addr[1] +: 16].
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Latency:
  - Accept at cycle T, MemReq high at T+1.
  - Best case (MemGnt at T+1, MemRValid at T+2): RspValid at T+3.
  - Error path: RspValid at T+1.
- Outputs are registered except ReqReady and MemReq, which are decoded from state.

Decomposition:
- Package load_pkg holds:
  - funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - cause codes CAUSE_OK, CAUSE_MISALIGN, CAUSE_TIMEOUT, CAUSE_ILLEGAL;
  - state enum {IDLE, REQ, WAIT, RESP}.
- One combinational sub-module, load_align_ext(word, off[1:0], funct3) -> 32-bit result. It does lane select plus sign/zero extension, so it can be unit-tested on its own.
- The FSM, timer and handshake live in the top module.

Test Plan:
- LB, addr=0x1003, MemRData=0x80FF1234, MemGnt same cycle, MemRValid 1 cycle later -> MemAddr=0x1000, RspData=0xFFFFFF80, cause 0, RspValid at T+3.
- LHU, addr=0x2002, MemRData=0xBEEF0001 -> RspData=0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- LW, addr=0x3001 -> no MemReq ever, RspValid at T+1, cause 1, RspData=0. funct3=011 -> cause 3.
- LW, addr=0x4000, MemGnt delayed 3 cycles -> MemAddr stable throughout, ReqReady=0 and a second ReqValid ignored. RspReady low 4 cycles -> RspData/RspCause held.
- TIMEOUT_CYC=8, MemGnt given but MemRValid never -> cause 2, RspData=0, 8 cycles after entering REQ. Variant with MemRValid on the timeout cycle -> cause 0 with data.
- Rst pulse while in WAIT -> IDLE immediately with all outputs 0. Stale MemRValid next cycle -> no RspValid. A fresh LBU then completes normally.
